// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch entry type passed between fetch-side blocks.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [31:0] RESET_PC  = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; head is visible combinationally for same-cycle pop.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output fetch_entry_t                 head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues pipelined imem requests, buffers responses and fills IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = pipeline_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        valid_id
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
        $error("FIFO_DEPTH must be 2 or 4");
    end

    logic                       rst_q;
    logic [31:0]                fetch_pc_q, fetch_pc_d;
    logic [31:0]                resp_pc_q, resp_pc_d;
    logic [CW-1:0]              outstanding_q, outstanding_d;
    logic [CW-1:0]              discard_q, discard_d;
    logic [31:0]                instr_q, instr_d;
    logic [31:0]                pc_id_q, pc_id_d;
    logic                       valid_q, valid_d;

    logic                       redirect;
    logic [31:0]                target;
    logic                       issue;
    logic                       resp_accept;
    logic                       resp_deliver;
    logic [CW:0]                in_flight;
    logic                       fifo_push, fifo_pop, fifo_flush;
    logic [CW-1:0]              fifo_count;
    pipeline_pkg::fetch_entry_t fifo_head;
    pipeline_pkg::fetch_entry_t resp_entry;
    logic                       unused_jump_lo;

    assign unused_jump_lo = ^JumpAddr[1:0];

    assign redirect  = IFWrite && (Branch || Jump);
    assign target    = {JumpAddr[31:2], 2'b00};
    assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};

    // Stay silent in the redirect cycle so nothing is fetched from the wrong path.
    assign imem_req  = !rst && !rst_q && !redirect && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    assign resp_accept  = imem_rvalid && (outstanding_q != '0);
    assign resp_deliver = resp_accept && (discard_q == '0);
    assign resp_entry   = '{pc: resp_pc_q, instr: imem_rdata};

    always_comb begin
        fetch_pc_d    = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d     = resp_deliver ? resp_pc_q + 32'd4 : resp_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(resp_accept);
        discard_d     = (resp_accept && discard_q != '0) ? discard_q - CW'(1) : discard_q;
        instr_d       = instr_q;
        pc_id_d       = pc_id_q;
        valid_d       = valid_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;

        if (redirect) begin
            // Everything still in flight is stale; a response landing now is dropped too.
            fetch_pc_d = target;
            resp_pc_d  = target;
            discard_d  = outstanding_d;
            fifo_flush = 1'b1;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else if (IFWrite) begin
            if (fifo_count != '0) begin
                fifo_pop  = 1'b1;
                fifo_push = resp_deliver;
                instr_d   = fifo_head.instr;
                pc_id_d   = fifo_head.pc;
                valid_d   = 1'b1;
            end else if (resp_deliver) begin
                instr_d = imem_rdata;
                pc_id_d = resp_pc_q;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else begin
            fifo_push = resp_deliver;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            instr_q       <= NOP_INSTR;
            pc_id_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            instr_q       <= instr_d;
            pc_id_q       <= pc_id_d;
            valid_q       <= valid_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign Instruction_id = instr_q;
    assign PC_id          = pc_id_q;
    assign valid_id       = valid_q;

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding_q <= CW'(FIFO_DEPTH));
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard_q <= CW'(FIFO_DEPTH));
    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> outstanding_q != '0);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model returning instr = addr.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        IFWrite;
    logic        Branch;
    logic        Jump;
    logic [31:0] JumpAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_id;
    logic [31:0] PC_id;
    logic        valid_id;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int mem_lat;

    logic [31:0] q_addr[$];
    int          q_due[$];

    if_fetch_unit #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IFWrite        (IFWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpAddr       (JumpAddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction_id (Instruction_id),
        .PC_id          (PC_id),
        .valid_id       (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accept on req&&gnt, answer in order mem_lat cycles later.
    always @(posedge clk) begin
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (imem_rvalid && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(cyc + mem_lat);
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = q_addr[0];
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEADBEEF;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where rst has just been released.
    task automatic do_reset(input int lat);
        rst      = 1'b1;
        IFWrite  = 1'b1;
        Branch   = 1'b0;
        Jump     = 1'b0;
        imem_gnt = 1'b1;
        go(2);
        mem_lat  = lat;
        rst      = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        IFWrite     = 1'b1;
        Branch      = 1'b0;
        Jump        = 1'b0;
        JumpAddr    = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_lat     = 1;

        // Reset state and straight-line fetch.
        do_reset(1);
        check_val("rst_instr", Instruction_id, NOP);
        check_val("rst_pc", PC_id, 32'h0);
        check_val("rst_valid", 32'(valid_id), 32'h0);
        #1 check_val("rst_req_first_cycle", 32'(imem_req), 32'h0);
        go(1);
        #1 check_val("first_req", 32'(imem_req), 32'h1);
        check_val("first_addr", imem_addr, 32'h0);
        go(2);
        check_val("seq_pc0", PC_id, 32'h0);
        check_val("seq_instr0", Instruction_id, 32'h0);
        check_val("seq_valid0", 32'(valid_id), 32'h1);
        go(1);
        check_val("seq_pc4", PC_id, 32'h4);
        go(1);
        check_val("seq_pc8", PC_id, 32'h8);

        // Decode stall for three cycles.
        IFWrite = 1'b0;
        go(1);
        check_val("stall_pc_a", PC_id, 32'h8);
        #1 check_val("stall_req_full", 32'(imem_req), 32'h0);
        go(1);
        check_val("stall_pc_b", PC_id, 32'h8);
        go(1);
        check_val("stall_pc_c", PC_id, 32'h8);
        check_val("stall_instr_c", Instruction_id, 32'h8);
        check_val("stall_valid_c", 32'(valid_id), 32'h1);
        IFWrite = 1'b1;
        go(1);
        check_val("after_stall_pc12", PC_id, 32'hC);
        go(1);
        check_val("after_stall_pc16", PC_id, 32'h10);
        go(1);
        check_val("after_stall_pc20", PC_id, 32'h14);
        check_val("after_stall_valid", 32'(valid_id), 32'h1);

        // Jump with two fetches in flight, two-cycle memory.
        do_reset(2);
        go(6);
        check_val("lat2_bubble_valid", 32'(valid_id), 32'h0);
        check_val("lat2_bubble_pc", PC_id, 32'h4);
        Jump     = 1'b1;
        JumpAddr = 32'h100;
        go(1);
        Jump = 1'b0;
        check_val("jmp_flush_valid", 32'(valid_id), 32'h0);
        check_val("jmp_flush_instr", Instruction_id, NOP);
        #1 check_val("jmp_addr", imem_addr, 32'h100);
        check_val("jmp_req", 32'(imem_req), 32'h1);
        go(1);
        check_val("jmp_drop_valid_a", 32'(valid_id), 32'h0);
        go(1);
        check_val("jmp_drop_valid_b", 32'(valid_id), 32'h0);
        go(1);
        check_val("jmp_pc100", PC_id, 32'h100);
        check_val("jmp_instr100", Instruction_id, 32'h100);
        check_val("jmp_valid100", 32'(valid_id), 32'h1);
        go(1);
        check_val("jmp_pc104", PC_id, 32'h104);

        // Branch during stall is ignored, then taken once IFWrite returns.
        do_reset(1);
        go(4);
        check_val("br_pre_pc", PC_id, 32'h4);
        Branch   = 1'b1;
        IFWrite  = 1'b0;
        JumpAddr = 32'h300;
        go(1);
        IFWrite = 1'b1;
        check_val("br_stall_pc", PC_id, 32'h4);
        check_val("br_stall_valid", 32'(valid_id), 32'h1);
        #1 check_val("br_stall_seq_addr", imem_addr, 32'h10);
        go(1);
        Branch = 1'b0;
        check_val("br_flush_valid", 32'(valid_id), 32'h0);
        #1 check_val("br_addr", imem_addr, 32'h300);
        go(2);
        check_val("br_pc300", PC_id, 32'h300);
        check_val("br_valid300", 32'(valid_id), 32'h1);
        go(1);
        check_val("br_pc304", PC_id, 32'h304);

        // Grant withheld for four cycles at 0x20.
        do_reset(1);
        go(9);
        imem_gnt = 1'b0;
        #1 check_val("gnt_addr_a", imem_addr, 32'h20);
        check_val("gnt_req_a", 32'(imem_req), 32'h1);
        go(1);
        check_val("gnt_pc28", PC_id, 32'h1C);
        #1 check_val("gnt_addr_b", imem_addr, 32'h20);
        go(1);
        check_val("gnt_bubble_a", 32'(valid_id), 32'h0);
        go(1);
        check_val("gnt_bubble_b", 32'(valid_id), 32'h0);
        #1 check_val("gnt_req_held", 32'(imem_req), 32'h1);
        check_val("gnt_addr_c", imem_addr, 32'h20);
        go(1);
        imem_gnt = 1'b1;
        go(2);
        check_val("gnt_pc20", PC_id, 32'h20);
        check_val("gnt_valid20", 32'(valid_id), 32'h1);
        go(1);
        check_val("gnt_pc24", PC_id, 32'h24);

        // PC wrap at the top of the address space, misaligned target.
        do_reset(1);
        go(5);
        Jump     = 1'b1;
        JumpAddr = 32'hFFFFFFFF;
        go(1);
        Jump = 1'b0;
        #1 check_val("wrap_addr", imem_addr, 32'hFFFFFFFC);
        go(2);
        check_val("wrap_pc_top", PC_id, 32'hFFFFFFFC);
        go(1);
        check_val("wrap_pc_zero", PC_id, 32'h0);
        check_val("wrap_instr_zero", Instruction_id, 32'h0);

        // Redirect concurrent with a response, then reset mid-stream.
        do_reset(1);
        go(5);
        Jump     = 1'b1;
        JumpAddr = 32'h203;
        go(1);
        Jump = 1'b0;
        check_val("rsp_flush_valid", 32'(valid_id), 32'h0);
        check_val("rsp_flush_instr", Instruction_id, NOP);
        #1 check_val("rsp_addr", imem_addr, 32'h200);
        go(1);
        check_val("rsp_dropped_valid", 32'(valid_id), 32'h0);
        go(1);
        check_val("rsp_pc200", PC_id, 32'h200);
        check_val("rsp_instr200", Instruction_id, 32'h200);
        check_val("rsp_valid200", 32'(valid_id), 32'h1);
        rst = 1'b1;
        go(1);
        check_val("mid_rst_instr", Instruction_id, NOP);
        check_val("mid_rst_pc", PC_id, 32'h0);
        check_val("mid_rst_valid", 32'(valid_id), 32'h0);
        #1 check_val("mid_rst_req", 32'(imem_req), 32'h0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
